// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 3-stage RV32I pipeline: redirect, load-use and LSU wait hazards.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned LSU_TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        br_taken,
  input  logic        jump,
  input  logic        ex_is_load,
  input  logic        ex_reg_wr,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  de_rs1,
  input  logic [4:0]  de_rs2,
  input  logic        de_use_rs1,
  input  logic        de_use_rs2,
  input  logic        lsu_req,
  input  logic        lsu_ack,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        lsu_busy,
  output logic        timeout_err,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {RUN, LSU_WAIT, FLUSH, LOAD_USE} state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic       timeout_set;
  logic       hz_lu;
  logic       redirect;
  logic       stall_pc_nxt, stall_fd_nxt, flush_fd_nxt, flush_de_nxt, lsu_busy_nxt;

  assign redirect = br_taken | jump;
  assign hz_lu = ex_is_load & ex_reg_wr & (ex_rd != 5'd0) &
                 ((de_use_rs1 & (de_rs1 == ex_rd)) | (de_use_rs2 & (de_rs2 == ex_rd)));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    fcnt_nxt     = fcnt;
    timeout_set  = 1'b0;
    case (state)
      RUN: begin
        if (lsu_req & ~lsu_ack) begin
          state_nxt    = LSU_WAIT;
          wait_cnt_nxt = 8'd1;
        end else if (redirect) begin
          state_nxt = FLUSH;
          fcnt_nxt  = 3'(FLUSH_CYCLES - 1);
        end else if (hz_lu) begin
          state_nxt = LOAD_USE;
        end
      end
      LSU_WAIT: begin
        if (lsu_ack) begin
          state_nxt = RUN;
        end else if (wait_cnt >= 8'(LSU_TIMEOUT)) begin
          state_nxt   = RUN;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      FLUSH: begin
        if (fcnt == 3'd0) state_nxt = RUN;
        else              fcnt_nxt  = fcnt - 3'd1;
      end
      LOAD_USE: begin
        if (redirect) begin
          state_nxt = FLUSH;
          fcnt_nxt  = 3'(FLUSH_CYCLES - 1);
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Controls are decoded from the next state so they are valid in the cycle the state is entered.
  always_comb begin
    stall_pc_nxt = 1'b0;
    stall_fd_nxt = 1'b0;
    flush_fd_nxt = 1'b0;
    flush_de_nxt = 1'b0;
    lsu_busy_nxt = 1'b0;
    case (state_nxt)
      LSU_WAIT: begin
        stall_pc_nxt = 1'b1;
        stall_fd_nxt = 1'b1;
        flush_de_nxt = 1'b1;
        lsu_busy_nxt = 1'b1;
      end
      FLUSH: begin
        flush_fd_nxt = 1'b1;
        flush_de_nxt = 1'b1;
      end
      LOAD_USE: begin
        stall_pc_nxt = 1'b1;
        stall_fd_nxt = 1'b1;
        flush_de_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      fcnt        <= '0;
      stall_pc    <= 1'b0;
      stall_fd    <= 1'b0;
      flush_fd    <= 1'b0;
      flush_de    <= 1'b0;
      lsu_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      fcnt        <= fcnt_nxt;
      stall_pc    <= stall_pc_nxt;
      stall_fd    <= stall_fd_nxt;
      flush_fd    <= flush_fd_nxt;
      flush_de    <= flush_de_nxt;
      lsu_busy    <= lsu_busy_nxt;
      timeout_err <= timeout_err | timeout_set;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= stall_count + {31'd0, stall_pc};
      if (state_nxt == FLUSH && state != FLUSH) flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 3-stage RV32I pipeline with integrated LSU and UART.
- Drives the hold and flush controls of the fetch-to-decode register and of the PC, and the flush of the decode-to-execute register.
- Resolves three hazard classes:
  - taken branch/jump redirect;
  - load-use data hazard;
  - LSU/UART memory wait with timeout.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles flush_fd/flush_de stay asserted after a redirect (1..7).
- LSU_TIMEOUT, 255, maximum LSU_WAIT cycles before timeout_err fires (1..255).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- br_taken  input  1  execute-stage branch resolved taken.
- jump  input  1  execute-stage jal/jalr.
- ex_is_load  input  1  execute-stage instruction is a load.
- ex_reg_wr  input  1  execute-stage instruction writes rd.
- ex_rd  input  5  execute-stage destination register.
- de_rs1  input  5  decode-stage source 1.
- de_rs2  input  5  decode-stage source 2.
- de_use_rs1  input  1  decode-stage instruction reads rs1.
- de_use_rs2  input  1  decode-stage instruction reads rs2.
- lsu_req  input  1  LSU transaction started this cycle (load/store to memory or UART).
- lsu_ack  input  1  LSU/UART transaction complete.
- stall_pc  output  1  hold PC.
- stall_fd  output  1  hold fetch-to-decode register.
- flush_fd  output  1  load NOP (0x00000013) into fetch-to-decode register.
- flush_de  output  1  bubble decode-to-execute register.
- lsu_busy  output  1  controller is in LSU_WAIT.
- timeout_err  output  1  sticky: LSU wait exceeded LSU_TIMEOUT.
- stall_count  output  32  performance counter (see Optional Feature).
- flush_count  output  32  performance counter (see Optional Feature).

Behaviour:
Reset values:
- While reset is low, all outputs are 0, state is RUN, and both counters are 0.
- Reset deassertion is asynchronous-assert with no sync requirement stated here; the integrator provides release synchronisation.

States: RUN, LSU_WAIT, FLUSH, LOAD_USE.

Combinational hazard term:
- hz_lu = ex_is_load & ex_reg_wr & (ex_rd != 0) & ((de_use_rs1 & de_rs1 == ex_rd) | (de_use_rs2 & de_rs2 == ex_rd)).

RUN, priority highest first:
1. lsu_req & !lsu_ack → LSU_WAIT; load wait counter with 1.
2. br_taken | jump → FLUSH; load flush counter with FLUSH_CYCLES-1.
3. hz_lu → LOAD_USE.
4. Otherwise stay in RUN.
- If lsu_req & lsu_ack occur in the same cycle, the access is a zero-wait access: no LSU_WAIT entry, and rules 2–4 are evaluated.

LSU_WAIT:
- stall_pc=1, stall_fd=1, flush_de=1, lsu_busy=1. The execute stage is frozen by the LSU itself.
- lsu_ack → RUN on the next cycle; outputs are deasserted in that RUN cycle.
- br_taken/jump/hz_lu are ignored while waiting; they are re-evaluated in RUN because execute holds.
- If the wait counter reaches LSU_TIMEOUT without ack: set timeout_err (sticky until reset) and go to RUN.

FLUSH:
- flush_fd=1, flush_de=1; stall_pc=0 so the PC takes the redirect target.
- Flush counter decrements each cycle; at 0 → RUN.
- With FLUSH_CYCLES=1, flush outputs are asserted for exactly one cycle: the cycle after br_taken is sampled (registered outputs).
- A new lsu_req during FLUSH is not possible because execute holds a bubble; it is ignored.

LOAD_USE:
- One cycle with stall_pc=1, stall_fd=1, flush_de=1, then → RUN.
- If br_taken|jump is asserted in this cycle, go to FLUSH next (the redirect wins over the re-issue).

Output timing:
- All outputs are registered and decoded from next-state, so each control is valid in the cycle the state is entered.
- Latency from hazard input to control output is 1 clock.

Reset mid-operation:
- Reset asserted in any state forces RUN and zeros all outputs immediately (asynchronous); timeout_err also clears.

Optional Feature:
Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - stall_count increments by 1 every cycle stall_pc=1.
  - flush_count increments by 1 on every entry into FLUSH.
  - Both counters are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops are synthesised.

Test Plan:
1. Reset low 3 cycles, then high → all outputs 0, state RUN; pulse reset low mid-LSU_WAIT → lsu_busy drops to 0 immediately.
2. br_taken=1 for 1 cycle, FLUSH_CYCLES=1 → flush_fd=flush_de=1 for exactly 1 cycle; stall_pc stays 0; flush_count becomes 1.
3. ex_is_load=1, ex_reg_wr=1, ex_rd=5, de_rs2=5, de_use_rs2=1 → one cycle of stall_pc=stall_fd=flush_de=1, then RUN. Repeat with ex_rd=0 → no stall.
4. lsu_req=1, lsu_ack held low 4 cycles, then pulsed → lsu_busy=1 for 4 cycles then 0; stall_count=4. Repeat with lsu_req&lsu_ack same cycle → no stall.
5. LSU_TIMEOUT=8, lsu_ack never asserted → after 8 wait cycles timeout_err=1 and stays 1; state returns to RUN.
6. LOAD_USE with br_taken=1 in the stall cycle → next cycle flush_fd=1 (FLUSH), no second load-use bubble.
